// File: rtl/regfile_wb_sched_if.sv
// Handshake and write-port bundle between issue, ALU, LSU and the write-back scheduler.
interface regfile_wb_sched_if #(
   parameter int XLEN         = 32,
   parameter int REG_ADDR_LEN = 5
);
   logic                    iss_valid;
   logic [REG_ADDR_LEN-1:0] iss_rs1;
   logic [REG_ADDR_LEN-1:0] iss_rs2;
   logic [REG_ADDR_LEN-1:0] iss_rd;
   logic                    iss_wr;
   logic                    iss_stall;

   logic                    alu_valid;
   logic [REG_ADDR_LEN-1:0] alu_rd;
   logic [XLEN-1:0]         alu_data;
   logic                    alu_ready;

   logic                    lsu_valid;
   logic [REG_ADDR_LEN-1:0] lsu_rd;
   logic [XLEN-1:0]         lsu_data;
   logic                    lsu_ready;

   logic                    rf_we;
   logic [REG_ADDR_LEN-1:0] rf_wa;
   logic [XLEN-1:0]         rf_wdata;

   modport slave (
      input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wr,
      output iss_stall,
      input  alu_valid, alu_rd, alu_data,
      output alu_ready,
      input  lsu_valid, lsu_rd, lsu_data,
      output lsu_ready,
      output rf_we, rf_wa, rf_wdata
   );

   modport master (
      output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wr,
      input  iss_stall,
      output alu_valid, alu_rd, alu_data,
      input  alu_ready,
      output lsu_valid, lsu_rd, lsu_data,
      input  lsu_ready,
      input  rf_we, rf_wa, rf_wdata
   );
endinterface

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: round-robin ALU/LSU arbitration onto one registered regfile
// write port, with a busy scoreboard that stalls issue on RAW/WAW hazards.
module regfile_wb_sched #(
   parameter int XLEN         = 32,
   parameter int REG_ADDR_LEN = 5
) (
   input logic               clk,
   input logic               reset,
   regfile_wb_sched_if.slave bus
);
   localparam int NREG = 1 << REG_ADDR_LEN;

   logic [NREG-1:0]         r_busy;
   logic                    r_last;
   logic                    r_we;
   logic [REG_ADDR_LEN-1:0] r_wa;
   logic [XLEN-1:0]         r_wdata;

   logic                    w_gnt_alu;
   logic                    w_gnt_lsu;
   logic                    w_gnt;
   logic [REG_ADDR_LEN-1:0] w_gnt_rd;
   logic [XLEN-1:0]         w_gnt_data;
   logic [NREG-1:0]         w_busy;
   logic                    w_stall;
   logic                    w_fire;
   logic [NREG-1:0]         w_busy_nxt;

   // r_last = 1 means the LSU was granted last, so the ALU wins the next tie
   always_comb begin
      w_gnt_alu = !reset && bus.alu_valid && (!bus.lsu_valid || r_last);
      w_gnt_lsu = !reset && bus.lsu_valid && (!bus.alu_valid || !r_last);
      w_gnt     = w_gnt_alu || w_gnt_lsu;
      if (w_gnt_lsu) begin
         w_gnt_rd   = bus.lsu_rd;
         w_gnt_data = bus.lsu_data;
      end else begin
         w_gnt_rd   = bus.alu_rd;
         w_gnt_data = bus.alu_data;
      end
   end

   always_comb begin
      w_busy    = r_busy;
      w_busy[0] = 1'b0;
      w_stall   = bus.iss_valid && (w_busy[bus.iss_rs1] || w_busy[bus.iss_rs2] ||
                                    (bus.iss_wr && w_busy[bus.iss_rd]));
      w_fire    = bus.iss_valid && !w_stall;
   end

   // Clear first, then set, so an issue to a register whose write commits this cycle stays busy
   always_comb begin
      w_busy_nxt = r_busy;
      if (r_we)
         w_busy_nxt[r_wa] = 1'b0;
      if (w_fire && bus.iss_wr && (bus.iss_rd != '0))
         w_busy_nxt[bus.iss_rd] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy  <= '0;
         r_last  <= 1'b1;
         r_we    <= 1'b0;
         r_wa    <= '0;
         r_wdata <= '0;
      end else begin
         r_busy <= w_busy_nxt;
         if (w_gnt) begin
            r_last  <= w_gnt_lsu;
            r_we    <= (w_gnt_rd != '0);
            r_wa    <= w_gnt_rd;
            r_wdata <= w_gnt_data;
         end else begin
            r_we <= 1'b0;
         end
      end
   end

   assign bus.iss_stall = w_stall;
   assign bus.alu_ready = w_gnt_alu;
   assign bus.lsu_ready = w_gnt_lsu;
   assign bus.rf_we     = r_we;
   assign bus.rf_wa     = r_wa;
   assign bus.rf_wdata  = r_wdata;
endmodule
